// File: rtl/tx_drain_if.sv
// FIFO-side and transmitter-side signal bundle of tx_drain_scheduler.
// master drives the FIFO view and tx_ready; slave is the scheduler.
interface tx_drain_if #(
  parameter int LG_FIFO_DEPTH = 12
);
  logic [7:0]             fifo_data;
  logic                   fifo_empty;
  logic [LG_FIFO_DEPTH:0] fifo_space_free;
  logic                   fifo_rdreq;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic                   busy;
  logic                   burst_done;

  modport master (
    output fifo_data, fifo_empty, fifo_space_free, tx_ready,
    input  fifo_rdreq, tx_data, tx_valid, busy, burst_done
  );

  modport slave (
    input  fifo_data, fifo_empty, fifo_space_free, tx_ready,
    output fifo_rdreq, tx_data, tx_valid, busy, burst_done
  );
endinterface

// File: rtl/tx_drain_scheduler.sv
// Drains a show-ahead byte FIFO toward a transmitter in bounded bursts.
// Define TX_DRAIN_TIMEOUT_EN to flush a partially filled FIFO after an idle timeout.
module tx_drain_scheduler #(
  parameter int LG_FIFO_DEPTH  = 12,
  parameter int THRESHOLD      = 16,
  parameter int BURST_MAX      = 64,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic      clk,
  input  logic      rst,
  tx_drain_if.slave bus
);
  localparam int LW = LG_FIFO_DEPTH + 1;
  localparam logic [LW-1:0] DEPTH = {1'b1, {LG_FIFO_DEPTH{1'b0}}};
  localparam logic [LW-1:0] THR   = LW'(THRESHOLD);
  localparam logic [LW-1:0] BMAX  = LW'(BURST_MAX);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] burst_cnt_q, burst_cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic [LW-1:0] level;
  logic          load_slot, burst_end, trigger;

  // Full LW-bit subtraction so a completely full FIFO reads as DEPTH, not zero.
  assign level = DEPTH - bus.fifo_space_free;

`ifdef TX_DRAIN_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          lvl_partial, to_hit;

  assign lvl_partial = (level != '0) && (level < THR);
  assign to_hit      = lvl_partial && (to_cnt_q == TO_LAST);

  always_comb begin
    to_cnt_d = '0;
    if ((state_q == S_IDLE) && lvl_partial && !to_hit)
      to_cnt_d = to_cnt_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end

  assign trigger = (level >= THR) || to_hit;
`else
  assign trigger = (level >= THR);
`endif

  assign load_slot = (state_q == S_BURST) && (!tx_valid_q || bus.tx_ready) &&
                     !bus.fifo_empty && (burst_cnt_q < BMAX);
  // Leave BURST only once nothing more can load and the held byte is gone.
  assign burst_end = ((burst_cnt_q == BMAX) || bus.fifo_empty) &&
                     (!tx_valid_q || bus.tx_ready);

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    if (load_slot) begin
      tx_data_d   = bus.fifo_data;
      tx_valid_d  = 1'b1;
      burst_cnt_d = burst_cnt_q + LW'(1);
    end else if (bus.tx_ready) begin
      tx_valid_d = 1'b0;
    end
    case (state_q)
      S_IDLE:  if (trigger) state_d = S_BURST;
      S_BURST: if (burst_end) state_d = S_GAP;
      S_GAP: begin
        state_d     = S_IDLE;
        burst_cnt_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      burst_cnt_q <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
    end
  end

  assign bus.fifo_rdreq = load_slot && !rst;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.burst_done = (state_q == S_GAP);
endmodule

// File: tb/tb_tx_drain_scheduler.sv
// Bench for tx_drain_scheduler: queue-based FIFO and byte scoreboard, rule-level burst
// model checked every cycle, directed scenarios with literal expectations, random phase.
module tb_tx_drain_scheduler;
  localparam int LG    = 4;
  localparam int THR   = 4;
  localparam int BMAX  = 8;
  localparam int TOC   = 10;
  localparam int DEPTH = 16;
`ifdef TX_DRAIN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_drain_if #(.LG_FIFO_DEPTH(LG)) bus ();

  tx_drain_scheduler #(
    .LG_FIFO_DEPTH (LG),
    .THRESHOLD     (THR),
    .BURST_MAX     (BMAX),
    .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  logic [7:0] xfer_d[$];
  int         xfer_c[$];
  int         blen[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, pop_cnt = 0, burst_len = 0, idle_run = 0;
  logic [7:0] next_val = 8'h01;
  bit started = 1'b0, have_prev = 1'b0;
  bit p_rst, p_tv, p_rdy, p_busy, exp_busy, exp_done, exp_valid;
  logic [7:0] p_td, exp_td;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic drive_fifo();
    bus.fifo_empty      = (fq.size() == 0);
    bus.fifo_data       = (fq.size() == 0) ? 8'h00 : fq[0];
    bus.fifo_space_free = 5'(DEPTH - fq.size());
  endtask

  // One clock: pop on the sampled rdreq, then apply pushes/ready/reset for the next cycle.
  task automatic tick(input int npush, input bit rdy, input bit r);
    logic pop;
    @(negedge clk);
    pop = bus.fifo_rdreq;
    @(posedge clk);
    #1;
    if (pop && fq.size() > 0) begin
      void'(fq.pop_front());
      pop_cnt++;
    end
    for (int i = 0; i < npush; i++) begin
      if (fq.size() < DEPTH) begin
        fq.push_back(next_val);
        exp_q.push_back(next_val);
        next_val = next_val + 8'd1;
      end
    end
    bus.tx_ready = rdy;
    rst = r;
    drive_fifo();
  endtask

  always @(negedge clk) begin
    int lvl;
    bit xfer;
    cyc++;
    lvl = fq.size();
    if (started) begin
      if (have_prev) begin
        if (p_rst) begin
          chk("reset_tx_valid", bus.tx_valid, 0);
          chk("reset_busy", bus.busy, 0);
          chk("reset_burst_done", bus.burst_done, 0);
          chk("reset_tx_data", bus.tx_data, 0);
        end else begin
          chk("busy_sequence", bus.busy, exp_busy);
          chk("burst_done_timing", bus.burst_done, exp_done);
          if (p_tv && !p_rdy) begin
            chk("stall_hold_valid", bus.tx_valid, 1);
            chk("stall_hold_data", bus.tx_data, p_td);
          end
          if (exp_valid) begin
            chk("load_valid", bus.tx_valid, 1);
            chk("load_data", bus.tx_data, exp_td);
          end
          if (exp_busy && !p_busy) chk("first_rdreq", bus.fifo_rdreq, 1);
        end
      end
      if (bus.fifo_empty) chk("rdreq_while_empty", bus.fifo_rdreq, 0);
      if (rst) chk("rdreq_in_reset", bus.fifo_rdreq, 0);
      if (bus.tx_valid && !bus.tx_ready) chk("rdreq_while_stalled", bus.fifo_rdreq, 0);
      if (bus.tx_valid) chk("valid_implies_busy", bus.busy, 1);

      xfer = bus.tx_valid && bus.tx_ready && !rst;
      if (xfer) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL tx_order at cycle %0d: got byte %0d, expected no byte", cyc, bus.tx_data);
        end else begin
          chk("tx_order", bus.tx_data, exp_q.pop_front());
        end
        burst_len++;
        xfer_d.push_back(bus.tx_data);
        xfer_c.push_back(cyc);
      end
      if (bus.burst_done) begin
        chk("burst_len_within_max", int'(burst_len <= BMAX), 1);
        blen.push_back(burst_len);
        burst_len = 0;
        done_cnt++;
      end
      if (rst) begin
        burst_len = 0;
        exp_q = fq;
      end

      idle_run = (!bus.busy && !rst && lvl > 0 && lvl < THR) ? idle_run + 1 : 0;
      if (!bus.busy) exp_busy = (lvl >= THR) || (TO_EN && idle_run == TOC);
      else           exp_busy = !bus.burst_done;
      exp_done  = bus.busy && !bus.burst_done &&
                  ((xfer && burst_len == BMAX) ||
                   (bus.fifo_empty && (!bus.tx_valid || bus.tx_ready)));
      exp_valid = bus.fifo_rdreq && !rst;
      exp_td    = (lvl > 0) ? fq[0] : 8'h00;
      p_rst  = rst;
      p_tv   = bus.tx_valid;
      p_rdy  = bus.tx_ready;
      p_td   = bus.tx_data;
      p_busy = bus.busy;
      have_prev = 1'b1;
    end
  end

  always @(negedge clk)
    if (started) assert (!(bus.fifo_rdreq && bus.fifo_empty))
      else $error("FAIL rdreq_with_empty at cycle %0d", cyc);

  initial begin
    int b0, d0, st, p0;
    bit rp[4];
    logic [7:0] v0;
    rp = '{1'b1, 1'b0, 1'b0, 1'b1};
    bus.tx_ready = 1'b0;
    drive_fifo();
    tick(0, 0, 1);
    started = 1'b1;
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("reset_state_busy", bus.busy, 0);
    chk("reset_state_valid", bus.tx_valid, 0);

    // Four bytes, threshold reached: one back-to-back burst
    b0 = xfer_d.size(); d0 = done_cnt;
    tick(4, 1, 0);
    st = cyc + 1;
    repeat (15) tick(0, 1, 0);
    chk("s1_count", xfer_d.size() - b0, 4);
    for (int i = 0; i < 4 && b0 + i < xfer_d.size(); i++) begin
      chk("s1_data", xfer_d[b0+i], i + 1);
      chk("s1_cycle", xfer_c[b0+i], st + 2 + i);
    end
    chk("s1_done_pulses", done_cnt - d0, 1);
    chk("s1_idle_after", bus.busy, 0);

    // Twelve bytes: 8-byte burst, gap, 4-byte burst
    b0 = xfer_d.size(); d0 = done_cnt;
    tick(12, 1, 0);
    repeat (40) tick(0, 1, 0);
    chk("s2_count", xfer_d.size() - b0, 12);
    for (int i = 0; i < 12 && b0 + i < xfer_d.size(); i++) chk("s2_data", xfer_d[b0+i], 5 + i);
    chk("s2_done_pulses", done_cnt - d0, 2);
    if (blen.size() >= 2) begin
      chk("s2_first_burst", blen[blen.size()-2], 8);
      chk("s2_second_burst", blen[blen.size()-1], 4);
    end

    // Ready toggling 1,0,0,1 through an 8-byte burst
    b0 = xfer_d.size(); d0 = done_cnt;
    tick(8, 1, 0);
    for (int i = 0; i < 40; i++) tick(0, rp[i%4], 0);
    repeat (5) tick(0, 1, 0);
    chk("s3_count", xfer_d.size() - b0, 8);
    for (int i = 0; i < 8 && b0 + i < xfer_d.size(); i++) chk("s3_data", xfer_d[b0+i], 17 + i);
    chk("s3_done_pulses", done_cnt - d0, 1);

    // Two bytes below threshold
    b0 = xfer_d.size();
    tick(2, 1, 0);
    st = cyc + 1;
    repeat (100) tick(0, 1, 0);
`ifdef TX_DRAIN_TIMEOUT_EN
    chk("s4_timeout_count", xfer_d.size() - b0, 2);
    if (xfer_d.size() - b0 >= 2) begin
      chk("s4_timeout_first_cycle", xfer_c[b0], st + 11);
      chk("s4_data0", xfer_d[b0], 25);
      chk("s4_data1", xfer_d[b0+1], 26);
    end
`else
    chk("s4_no_output", xfer_d.size() - b0, 0);
    tick(2, 1, 0);
    repeat (20) tick(0, 1, 0);
    chk("s4_flush_count", xfer_d.size() - b0, 4);
    for (int i = 0; i < 4 && b0 + i < xfer_d.size(); i++) chk("s4_data", xfer_d[b0+i], 25 + i);
`endif

    // Reset mid-burst after the third pop
    b0 = xfer_d.size(); d0 = done_cnt; v0 = next_val;
    tick(8, 1, 0);
    p0 = pop_cnt;
    for (int i = 0; i < 50 && pop_cnt - p0 < 3; i++) tick(0, 1, 0);
    chk("s5_third_pop_reached", pop_cnt - p0, 3);
    rst = 1'b1;
    tick(0, 1, 0);
    chk("s5_valid_after_rst", bus.tx_valid, 0);
    chk("s5_busy_after_rst", bus.busy, 0);
    chk("s5_rdreq_after_rst", bus.fifo_rdreq, 0);
    chk("s5_fifo_left", fq.size(), 5);
    repeat (30) tick(0, 1, 0);
    chk("s5_count", xfer_d.size() - b0, 7);
    if (xfer_d.size() - b0 >= 7) begin
      chk("s5_data0", xfer_d[b0], v0);
      chk("s5_data1", xfer_d[b0+1], v0 + 8'd1);
      for (int i = 2; i < 7; i++) chk("s5_data_rest", xfer_d[b0+i], 8'(v0 + 8'(i + 1)));
    end
    chk("s5_done_pulses", done_cnt - d0, 1);
    if (blen.size() >= 1) chk("s5_fresh_burst", blen[blen.size()-1], 5);

    // Random traffic, stalls and occasional resets
    for (int i = 0; i < 3000; i++) begin
      int np;
      bit rd, rs;
      np = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      rd = ($urandom_range(0, 9) < 7);
      rs = ($urandom_range(0, 499) == 0);
      tick(np, rd, rs);
    end
    repeat (60) tick(0, 1, 0);
    chk("end_scoreboard_drained", exp_q.size(), fq.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tx_drain_scheduler.md
TX_DRAIN_SCHEDULER -- requirements
Module: tx_drain_scheduler

Interface
REQ-001 Parameter: LG_FIFO_DEPTH, default 12, log2 of the attached byte FIFO depth.
REQ-002 Parameter: THRESHOLD, default 16, minimum FIFO fill level that starts a burst; legal range 1..2^LG_FIFO_DEPTH.
REQ-003 Parameter: BURST_MAX, default 64, maximum bytes per burst; legal range 1..2^LG_FIFO_DEPTH.
REQ-004 Parameter: TIMEOUT_CYCLES, default 1000, idle-wait limit before a partial flush; must be >=2.
REQ-005 Port: clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 Port: rst, input, 1, synchronous active-high reset.
REQ-007 Port: fifo_data, input, 8, show-ahead FIFO head byte, valid whenever fifo_empty=0.
REQ-008 Port: fifo_empty, input, 1, FIFO empty flag.
REQ-009 Port: fifo_space_free, input, LG_FIFO_DEPTH+1, FIFO free entries.
REQ-010 Port: fifo_rdreq, output, 1, pop strobe; head advances on the same clock edge.
REQ-011 Port: tx_data, output, 8, byte offered to the transmitter.
REQ-012 Port: tx_valid, output, 1, tx_data valid.
REQ-013 Port: tx_ready, input, 1, transmitter accepts; transfer when tx_valid=1 and tx_ready=1 on a rising edge.
REQ-014 Port: busy, output, 1, high when state is not IDLE.
REQ-015 Port: burst_done, output, 1, one-cycle pulse at the end of every burst.

Function
REQ-016 Fill level SHALL be computed as 2^LG_FIFO_DEPTH - fifo_space_free in LG_FIFO_DEPTH+1 bits, with no truncation.
REQ-017 States SHALL be IDLE, BURST, GAP; encoding is free.
REQ-018 IDLE->BURST SHALL occur on the edge where fill level >= THRESHOLD, or on a timeout trigger (REQ-030); otherwise IDLE is held.
REQ-019 In BURST, a load slot exists when (tx_valid=0 or tx_ready=1), fifo_empty=0, and burst_cnt < BURST_MAX.
REQ-020 fifo_rdreq SHALL be combinational: 1 only in BURST during a load slot, never while rst=1, and never while fifo_empty=1.
REQ-021 On a load slot, tx_data SHALL register fifo_data, tx_valid SHALL be set to 1, and burst_cnt SHALL increment; this sustains one byte per cycle while tx_ready=1.
REQ-022 While tx_valid=1 and tx_ready=0, tx_data and tx_valid SHALL hold stable.
REQ-023 On a transfer with no load slot, tx_valid SHALL clear on the next edge.
REQ-024 BURST->GAP SHALL occur once (burst_cnt=BURST_MAX or fifo_empty=1) and the last loaded byte has transferred, so tx_valid falls.
REQ-025 burst_done SHALL pulse for exactly the one cycle spent in GAP.
REQ-026 GAP->IDLE SHALL occur unconditionally after one cycle; burst_cnt SHALL clear on entry to IDLE.
REQ-027 Latency: trigger seen in IDLE at cycle N gives busy=1 and the first fifo_rdreq at N+1, and tx_valid=1 at N+2.
REQ-028 FIFO emptying mid-burst SHALL end the burst early (REQ-024); there is no wait for refill.

Reset
REQ-029 With rst=1 at an edge, the following SHALL apply regardless of state, including mid-burst: state=IDLE, tx_valid=0, tx_data=0, burst_cnt=0, timeout count=0, burst_done=0, busy=0. fifo_rdreq SHALL be 0 during reset, and an unaccepted tx byte SHALL be discarded.

Configuration
REQ-030 Macro TX_DRAIN_TIMEOUT_EN: when defined, an IDLE counter SHALL increment each cycle while 0 < level < THRESHOLD and clear otherwise. On reaching TIMEOUT_CYCLES-1, the next edge SHALL enter BURST and clear the counter.
REQ-031 Without TX_DRAIN_TIMEOUT_EN: no counter logic SHALL exist, and only level >= THRESHOLD starts a burst.

Verification (bench: LG_FIFO_DEPTH=4, THRESHOLD=4, BURST_MAX=8, TIMEOUT_CYCLES=10)
REQ-032 Push 0x01..0x04, tx_ready=1 -> bytes 0x01..0x04 out on 4 consecutive cycles; burst_done pulses once; then IDLE with busy=0.
REQ-033 Push 12 bytes, tx_ready=1 -> first burst 8 bytes, GAP, then second burst 4 bytes; exactly 2 burst_done pulses; order preserved.
REQ-034 Burst with tx_ready toggling 1,0,0,1 -> tx_data held during stalls; no fifo_rdreq while stalled; no byte lost or duplicated.
REQ-035 Push 2 bytes, macro defined -> burst starts 10 cycles later, 2 bytes sent; macro undefined -> no output for 100 cycles.
REQ-036 Assert rst for 1 cycle after the 3rd byte of an 8-byte burst -> next cycle tx_valid=0, busy=0, fifo_rdreq=0; remaining 5 bytes in FIFO start a fresh burst.
REQ-037 Every scenario: fifo_rdreq=1 with fifo_empty=1 never occurs (checked by assertion).
